// File: rtl/tm_seq_inference_if.sv
// Handshake and config bundle for the sequential Tsetlin Machine engine.
// The engine uses the slave view and the driving side uses the master view.
interface tm_seq_inference_if #(
   parameter int N_FEATURES = 2,
   parameter int N_CLAUSES  = 4,
   parameter int N_CLASSES  = 2
);
   localparam int ADDR_W  = $clog2(N_CLASSES * N_CLAUSES);
   localparam int CLASS_W = $clog2(N_CLASSES);
   localparam int SW      = $clog2(N_CLAUSES / 2 + 1) + 1;

   logic                    cfg_we;
   logic [ADDR_W-1:0]       cfg_addr;
   logic [2*N_FEATURES-1:0] cfg_data;
   logic                    in_valid;
   logic                    in_ready;
   logic [N_FEATURES-1:0]   features;
   logic                    out_valid;
   logic                    out_ready;
   logic [CLASS_W-1:0]      out_class;
   logic signed [SW-1:0]    out_score;
   logic                    busy;

   modport master (
      output cfg_we, cfg_addr, cfg_data, in_valid, features, out_ready,
      input  in_ready, out_valid, out_class, out_score, busy
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, in_valid, features, out_ready,
      output in_ready, out_valid, out_class, out_score, busy
   );
endinterface

// File: rtl/tm_seq_inference.sv
// Sequential Tsetlin Machine inference: evaluates one clause per clock, accumulates
// signed per-class votes, then reports the argmax class (lowest index wins ties).
module tm_seq_inference #(
   parameter int N_FEATURES = 2,
   parameter int N_CLAUSES  = 4,
   parameter int N_CLASSES  = 2
) (
   input logic               clk,
   input logic               rst_n,
   tm_seq_inference_if.slave bus
);
   localparam int TOTAL   = N_CLASSES * N_CLAUSES;
   localparam int LW      = 2 * N_FEATURES;
   localparam int ADDR_W  = $clog2(TOTAL);
   localparam int CLASS_W = $clog2(N_CLASSES);
   localparam int SW      = $clog2(N_CLAUSES / 2 + 1) + 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      DECIDE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                state_r;
   logic [LW-1:0]         mask_r [TOTAL];
   logic [N_FEATURES-1:0] feat_r;
   logic [ADDR_W-1:0]     cnt_r;
   logic signed [SW-1:0]  sum_r [N_CLASSES];
   logic                  in_ready_r;
   logic                  out_valid_r;
   logic                  busy_r;
   logic [CLASS_W-1:0]    out_class_r;
   logic signed [SW-1:0]  out_score_r;

   logic [LW-1:0]         lits_s;
   logic                  clause_hit_s;
   logic [CLASS_W-1:0]    cls_s;
   logic                  last_s;
   logic                  cfg_ok_s;
   logic                  accept_s;
   logic [CLASS_W-1:0]    best_idx_s;
   logic signed [SW-1:0]  best_sum_s;

   // An empty mask never fires, otherwise every included literal must be 1.
   function automatic logic clause_fire(input logic [LW-1:0] mask, input logic [LW-1:0] lits);
      return (mask != {LW{1'b0}}) && ((mask & ~lits) == {LW{1'b0}});
   endfunction

   // Current clause evaluation, config qualification and input handshake.
   always_comb begin
      lits_s       = {~feat_r, feat_r};
      clause_hit_s = clause_fire(mask_r[cnt_r], lits_s);
      cls_s        = CLASS_W'(int'(cnt_r) / N_CLAUSES);
      last_s       = (cnt_r == ADDR_W'(TOTAL - 1));
      cfg_ok_s     = bus.cfg_we && (state_r == IDLE) &&
                     ({1'b0, bus.cfg_addr} < (ADDR_W + 1)'(TOTAL));
      accept_s     = bus.in_valid && in_ready_r;
   end

   // Argmax over class sums; strict compare keeps the lowest index on ties.
   always_comb begin
      best_idx_s = {CLASS_W{1'b0}};
      best_sum_s = sum_r[0];
      for (int i = 1; i < N_CLASSES; i++) begin
         best_idx_s = (sum_r[i] > best_sum_s) ? CLASS_W'(i) : best_idx_s;
         best_sum_s = (sum_r[i] > best_sum_s) ? sum_r[i] : best_sum_s;
      end
   end

   // Clause mask bank; writes outside IDLE are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TOTAL; i++) begin
            mask_r[i] <= {LW{1'b0}};
         end
      end else if (cfg_ok_s) begin
         mask_r[bus.cfg_addr] <= bus.cfg_data;
      end
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         feat_r      <= {N_FEATURES{1'b0}};
         cnt_r       <= {ADDR_W{1'b0}};
         for (int i = 0; i < N_CLASSES; i++) begin
            sum_r[i] <= {SW{1'b0}};
         end
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         out_class_r <= {CLASS_W{1'b0}};
         out_score_r <= {SW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  feat_r <= bus.features;
                  cnt_r  <= {ADDR_W{1'b0}};
                  for (int i = 0; i < N_CLASSES; i++) begin
                     sum_r[i] <= {SW{1'b0}};
                  end
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
                  state_r    <= EVAL;
               end
            end
            EVAL: begin
               if (clause_hit_s) begin
                  sum_r[cls_s] <= cnt_r[0] ? (sum_r[cls_s] - SW'(1)) : (sum_r[cls_s] + SW'(1));
               end
               if (last_s) begin
                  state_r <= DECIDE;
               end else begin
                  cnt_r <= cnt_r + ADDR_W'(1);
               end
            end
            DECIDE: begin
               out_class_r <= best_idx_s;
               out_score_r <= best_sum_s;
               out_valid_r <= 1'b1;
               state_r     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               busy_r      <= 1'b0;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.out_class = out_class_r;
   assign bus.out_score = out_score_r;
endmodule

// File: tb/tb_tm_seq_inference.sv
// Self-checking bench for tm_seq_inference: XOR vector table, corner-case
// sequences, and random masks/features against a behavioural vote model.
module tb_tm_seq_inference;
   localparam int NF   = 2;
   localparam int NCL  = 4;
   localparam int NCLS = 2;
   localparam int TOT  = NCL * NCLS;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [3:0] mdl_mask [TOT];

   tm_seq_inference_if #(.N_FEATURES(NF), .N_CLAUSES(NCL), .N_CLASSES(NCLS)) bus ();

   tm_seq_inference #(.N_FEATURES(NF), .N_CLAUSES(NCL), .N_CLASSES(NCLS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: vote count per class from literal rules, then first maximum.
   task automatic model(input logic [1:0] f, output logic signed [31:0] cls, output logic signed [31:0] score);
      int sums [NCLS];
      for (int k = 0; k < NCLS; k++) begin
         sums[k] = 0;
         for (int j = 0; j < NCL; j++) begin
            logic [3:0] m;
            logic [3:0] lit;
            bit fires;
            m = mdl_mask[k * NCL + j];
            lit = {~f[1], ~f[0], f[1], f[0]};
            fires = (m != 4'd0);
            for (int b = 0; b < 4; b++) begin
               if (m[b] && !lit[b]) fires = 1'b0;
            end
            if (fires) sums[k] += (j % 2 == 0) ? 1 : -1;
         end
      end
      cls = 0;
      score = sums[0];
      for (int k = 1; k < NCLS; k++) begin
         if (sums[k] > score) begin
            cls = k;
            score = sums[k];
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < TOT; i++) mdl_mask[i] = 4'd0;
      @(negedge clk);
   endtask

   task automatic write_mask(input int addr, input logic [3:0] data);
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 3'(addr);
      bus.cfg_data = data;
      @(posedge clk);
      @(negedge clk);
      bus.cfg_we = 1'b0;
      mdl_mask[addr] = data;
   endtask

   task automatic load_xor();
      logic [3:0] xm [TOT];
      xm[0] = 4'b0011; xm[1] = 4'b1001; xm[2] = 4'b1100; xm[3] = 4'b0110;
      xm[4] = 4'b1001; xm[5] = 4'b0011; xm[6] = 4'b0110; xm[7] = 4'b1100;
      for (int i = 0; i < TOT; i++) write_mask(i, xm[i]);
   endtask

   // Presents a vector at a negedge and returns at the negedge after acceptance.
   task automatic start_sample(input logic [1:0] f);
      int n;
      n = 0;
      bus.features = f;
      bus.in_valid = 1'b1;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("accept_timeout", n, 0);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_result(input int start);
      int lat;
      bit ir;
      lat = start;
      ir = 1'b0;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         if (bus.in_ready !== 1'b0) ir = 1'b1;
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 10);
      check("in_ready_low_busy", ir, 0);
   endtask

   task automatic handshake();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("post_hs_in_ready", bus.in_ready, 1);
      check("post_hs_out_valid", bus.out_valid, 0);
   endtask

   task automatic run_sample(input logic [1:0] f, output logic signed [31:0] cls, output logic signed [31:0] score);
      start_sample(f);
      wait_result(1);
      cls = bus.out_class;
      score = $signed(bus.out_score);
      handshake();
   endtask

   typedef struct {
      logic [1:0] f;
      int         cls;
      int         score;
   } vec_t;

   initial begin
      vec_t vecs [4];
      logic signed [31:0] c;
      logic signed [31:0] s;
      logic signed [31:0] ec;
      logic signed [31:0] es;
      logic signed [31:0] hc;
      logic signed [31:0] hs;

      total = 0;
      bad = 0;
      bus.cfg_we = 1'b0;
      bus.cfg_addr = 3'd0;
      bus.cfg_data = 4'd0;
      bus.in_valid = 1'b0;
      bus.features = 2'b00;
      bus.out_ready = 1'b0;

      vecs[0] = '{f: 2'b00, cls: 0, score: 1};
      vecs[1] = '{f: 2'b01, cls: 1, score: 1};
      vecs[2] = '{f: 2'b10, cls: 1, score: 1};
      vecs[3] = '{f: 2'b11, cls: 0, score: 1};

      do_reset();
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_out_class", bus.out_class, 0);
      check("rst_out_score", $signed(bus.out_score), 0);

      // All masks empty: every sum is 0 and the tie goes to class 0.
      run_sample(2'b10, c, s);
      check("tie_class", c, 0);
      check("tie_score", s, 0);

      load_xor();
      for (int i = 0; i < 4; i++) begin
         run_sample(vecs[i].f, c, s);
         check($sformatf("xor_class_%0d", i), c, vecs[i].cls);
         check($sformatf("xor_score_%0d", i), s, vecs[i].score);
      end

      // Backpressure: result held for 5 cycles, in_valid pulse ignored.
      start_sample(2'b01);
      wait_result(1);
      hc = bus.out_class;
      hs = $signed(bus.out_score);
      check("bp_class", hc, 1);
      check("bp_score", hs, 1);
      for (int i = 0; i < 5; i++) begin
         bus.features = 2'b10;
         bus.in_valid = (i == 2);
         @(negedge clk);
         check("bp_valid_held", bus.out_valid, 1);
         check("bp_class_held", bus.out_class, hc);
         check("bp_score_held", $signed(bus.out_score), hs);
         check("bp_in_ready_low", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
      handshake();
      check("bp_idle_busy", bus.busy, 0);

      // Config write together with accept: the new mask applies to this sample.
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 3'd4;
      bus.cfg_data = 4'b0000;
      start_sample(2'b01);
      bus.cfg_we = 1'b0;
      mdl_mask[4] = 4'b0000;
      wait_result(1);
      model(2'b01, ec, es);
      check("same_cycle_class", bus.out_class, ec);
      check("same_cycle_score", $signed(bus.out_score), es);
      check("same_cycle_class_abs", bus.out_class, 1);
      check("same_cycle_score_abs", $signed(bus.out_score), 0);
      handshake();
      write_mask(4, 4'b1001);

      // Config write while busy is dropped.
      start_sample(2'b01);
      @(negedge clk);
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 3'd4;
      bus.cfg_data = 4'b0000;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      wait_result(3);
      check("busy_wr_class", bus.out_class, 1);
      check("busy_wr_score", $signed(bus.out_score), 1);
      handshake();
      run_sample(2'b01, c, s);
      check("busy_wr_rerun_class", c, 1);
      check("busy_wr_rerun_score", s, 1);

      // Random masks and features against the reference model.
      for (int t = 0; t < 24; t++) begin
         logic [1:0] f;
         for (int w = 0; w < 2; w++) begin
            write_mask(int'($urandom_range(0, TOT - 1)), 4'($urandom_range(0, 15)));
         end
         f = 2'($urandom_range(0, 3));
         model(f, ec, es);
         run_sample(f, c, s);
         check($sformatf("rand_class_%0d", t), c, ec);
         check($sformatf("rand_score_%0d", t), s, es);
      end

      // Reset mid-EVAL: no result, masks cleared.
      load_xor();
      start_sample(2'b01);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_busy", bus.busy, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < TOT; i++) mdl_mask[i] = 4'd0;
      @(negedge clk);
      check("mid_rst_in_ready", bus.in_ready, 1);
      check("mid_rst_out_class", bus.out_class, 0);
      check("mid_rst_out_score", $signed(bus.out_score), 0);
      begin
         bit v;
         v = 1'b0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) v = 1'b1;
         end
         check("mid_rst_no_result", v, 0);
      end
      run_sample(2'b01, c, s);
      check("mid_rst_rerun_class", c, 0);
      check("mid_rst_rerun_score", s, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tm_seq_inference.md
Name: tm_seq_inference

Overview:
- Sequential, parametrised Tsetlin Machine inference engine for multi-class classification.
- Holds the include masks for every clause of every class in an internal register bank, loaded through a config write port.
- Accepts one feature vector per transaction over a valid/ready handshake and evaluates one clause per clock.
- Accumulates signed class votes, then returns the argmax class and its score over a valid/ready result handshake.

Parameters:
- N_FEATURES, 2: boolean features per sample; the literal count is 2*N_FEATURES.
- N_CLAUSES, 4: clauses per class; must be even.
- N_CLASSES, 2: number of classes; must be at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_we  in  1  mask write strobe.
- cfg_addr  in  $clog2(N_CLASSES*N_CLAUSES)  clause index = class*N_CLAUSES + clause.
- cfg_data  in  2*N_FEATURES  include mask for the addressed clause.
- in_valid  in  1  feature vector valid.
- in_ready  out  1  engine can accept a vector.
- features  in  N_FEATURES  feature vector; bit i is x_i.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_class  out  $clog2(N_CLASSES)  winning class index.
- out_score  out  SW  signed vote sum of the winning class; SW = $clog2(N_CLAUSES/2+1)+1.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Literal vector L (2*N_FEATURES bits):
  - L[i] = x_i for i < N_FEATURES.
  - L[N_FEATURES+i] = ~x_i.
- Clause output: 1 iff the mask is nonzero AND every literal whose mask bit is 1 equals 1. An all-zero mask always outputs 0.
- Polarity: even clause index votes +1 when its output is 1; odd index votes -1.
- Class sums are signed, width SW, and cannot overflow by construction.
- FSM states: IDLE, EVAL, DECIDE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch features, clear all sums, set clause counter to 0, go to EVAL.
- EVAL:
  - Each cycle, evaluate clause counter c, where class = c / N_CLAUSES, and add its vote to that class's sum.
  - After the cycle that evaluates c = N_CLASSES*N_CLAUSES-1, go to DECIDE. The counter does not wrap.
- DECIDE:
  - Argmax over the class sums.
  - Ties resolve to the lowest class index.
  - Register out_class and out_score, then go to DONE.
- DONE:
  - out_valid=1; out_class and out_score are held stable until out_valid&out_ready.
  - On that handshake go to IDLE.
- Latency: with the accept edge at cycle k, out_valid rises at cycle k + N_CLASSES*N_CLAUSES + 2. Throughput is one sample per N_CLASSES*N_CLAUSES+3 cycles with out_ready held high.
- No input pipelining: in_ready=0 in EVAL, DECIDE and DONE. in_valid asserted in those states is ignored, and the vector is not captured.
- Config writes:
  - Take effect on the clock edge when cfg_we=1 and the FSM is in IDLE.
  - When the FSM is in any other state, the write is silently dropped.
  - A write and an in handshake in the same IDLE cycle: the write is applied first, and the sample uses the new mask.
- Reset (asynchronous, at any time including mid-EVAL):
  - FSM to IDLE; in_ready=1 after release.
  - out_valid=0, out_class=0, out_score=0, busy=0.
  - All sums, all masks and the clause counter cleared to 0.
  - The in-flight sample is discarded and no result is produced.
- cfg_addr >= N_CLASSES*N_CLAUSES: the write is ignored.

Test Plan:
- XOR masks (defaults):
  - Class1 clause masks = 4'b1001, 4'b0011, 4'b0110, 4'b1100.
  - Class0 clause masks = 4'b0011, 4'b1001, 4'b1100, 4'b0110.
  - Inputs 00, 01, 10, 11 -> out_class = 0, 1, 1, 0, with out_score = +1 for every input.
  - Expected sums: input 01 -> class1 +1, class0 -1; input 00 -> class0 +1, class1 -1.
- Latency check: accept at cycle k -> out_valid first high at k+10. in_ready=0 from k+1 until the cycle after the result handshake.
- Tie and empty clauses: after reset (all masks zero), features=2'b10 -> out_class=0, out_score=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, and an in_valid pulse is not captured. Raising out_ready -> one handshake, then return to IDLE.
- Config while busy: load the XOR masks, start features=2'b01, then write class1 clause0 mask = 4'b0000 during EVAL. Required: result is class 1, score +1. A rerun of 01 after the engine returns to IDLE still gives class 1, because the write was dropped.
- Reset mid-EVAL: assert rst_n=0 at accept+3 -> out_valid stays 0 and masks are cleared. After release, features=2'b01 -> class 0, score 0.
